// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Optional high-water-mark tracking is enabled with the STACK_HWM_EN macro.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } op_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Stack control/status bundle; master drives ops, slave is the stack.
// The hwm signal exists only when STACK_HWM_EN is defined.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int CW = stack_pkg::clog2_cnt(DEPTH);

  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef STACK_HWM_EN
  logic [CW-1:0]    hwm;

  modport master (output push, pop, flush, din,
                  input  dout, empty, full, count, overflow, underflow, hwm);
  modport slave  (input  push, pop, flush, din,
                  output dout, empty, full, count, overflow, underflow, hwm);
`else
  modport master (output push, pop, flush, din,
                  input  dout, empty, full, count, overflow, underflow);
  modport slave  (input  push, pop, flush, din,
                  output dout, empty, full, count, overflow, underflow);
`endif
endinterface

// File: rtl/param_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-power-of-two depths leave unused address codes; read them as zero.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered top-of-stack, flags, error pulses and flush.
// Define STACK_HWM_EN to add the high-water-mark register and port.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  param_stack_if.slave  s
);
  localparam int CW = clog2_cnt(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  op_t              op;
  logic [CW-1:0]    count_q, count_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt, rdata;
  logic             ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic             we, empty, full;
  logic [AW-1:0]    waddr, raddr;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  // Entry beneath the current top; only consumed when count >= 2.
  assign raddr = AW'(count_q - CW'(2));

  always_comb begin
    op = OP_NONE;
    if (s.push && s.pop && !empty) op = OP_REPL;
    else if (s.push)               op = OP_PUSH;
    else if (s.pop)                op = OP_POP;
  end

  always_comb begin
    count_nxt = count_q;
    dout_nxt  = dout_q;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    we        = 1'b0;
    waddr     = AW'(count_q);
    if (s.flush) begin
      count_nxt = '0;
      dout_nxt  = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) ovf_nxt = 1'b1;
          else begin
            we        = 1'b1;
            count_nxt = count_q + CW'(1);
            dout_nxt  = s.din;
          end
        end
        OP_POP: begin
          if (empty) unf_nxt = 1'b1;
          else begin
            count_nxt = count_q - CW'(1);
            dout_nxt  = (count_q == CW'(1)) ? '0 : rdata;
          end
        end
        OP_REPL: begin
          we       = 1'b1;
          waddr    = AW'(count_q - CW'(1));
          dout_nxt = s.din;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      dout_q  <= dout_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we && rst_n),
    .waddr (waddr),
    .wdata (s.din),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign s.dout      = dout_q;
  assign s.count     = count_q;
  assign s.empty     = empty;
  assign s.full      = full;
  assign s.overflow  = ovf_q;
  assign s.underflow = unf_q;

`ifdef STACK_HWM_EN
  logic [CW-1:0] hwm_q;
  // Tracks the post-edge count, so flush (count_nxt=0) never lowers it.
  always_ff @(posedge clk) begin
    if (!rst_n)                 hwm_q <= '0;
    else if (count_nxt > hwm_q) hwm_q <= count_nxt;
  end
  assign s.hwm = hwm_q;
`endif
endmodule
